// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
// Routes read data back to its issuer after LATENCY cycles and sequences full-array zero clears.
module ram_port_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SIZE           = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned AW            = $clog2(SIZE),
  localparam int unsigned IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][AW-1:0]           req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  input  logic                                 clear_req,
  output logic                                 busy,
  output logic                                 ram_en,
  output logic                                 ram_we,
  output logic [AW-1:0]                        ram_addr,
  output logic [DATA_WIDTH-1:0]                ram_din,
  input  logic [DATA_WIDTH-1:0]                ram_dout
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [AW-1:0]                clr_cnt;
  logic [AW-1:0]                clr_cnt_nxt;
  logic [IW-1:0]                rr_ptr;
  logic [IW-1:0]                rr_ptr_nxt;

  logic                         grant_any;
  logic [IW-1:0]                grant_idx;
  logic [IW-1:0]                scan_idx;

  logic [LATENCY-1:0]           tag_v;
  logic [LATENCY-1:0][IW-1:0]   tag_id;
  logic                         push_v;
  logic [IW-1:0]                push_id;
  logic                         pipe_busy;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = IW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign pipe_busy = |tag_v;

  // Next-state and RAM-port steering
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    rr_ptr_nxt  = rr_ptr;
    req_ready   = '0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    busy        = 1'b0;
    push_v      = 1'b0;
    push_id     = grant_idx;

    case (state)
      ST_CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        busy     = 1'b1;
        if (clr_cnt == AW'(SIZE - 1)) begin
          clr_cnt_nxt = '0;
          state_nxt   = ST_RUN;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nxt = ST_DRAIN;
        end else if (grant_any) begin
          req_ready  = NUM_REQ'(1) << grant_idx;
          ram_en     = 1'b1;
          ram_we     = req_we[grant_idx];
          ram_addr   = req_addr[grant_idx];
          ram_din    = req_wdata[grant_idx];
          rr_ptr_nxt = grant_idx;
          push_v     = !req_we[grant_idx];
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) begin
          state_nxt = ST_CLEAR;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase

    // Reset must silence the port immediately, without waiting for a clock edge
    if (rst) begin
      req_ready = '0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      busy      = 1'b0;
      push_v    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Tag pipeline aligned with the RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= push_v;
      tag_id[0] <= push_id;
      for (int i = 1; i < int'(LATENCY); i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid = (tag_v[LATENCY-1] && !rst) ? (NUM_REQ'(1) << tag_id[LATENCY-1]) : '0;
  assign rsp_rdata = ram_dout;

  always_comb begin
    assert ($onehot0(req_ready));
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: two instances (LATENCY=2 and LATENCY=1) share stimulus,
// each with its own behavioural RAM; table vectors plus hand-written clear/reset sequences.
module tb_ram_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SZ = 16;
  localparam int unsigned AW = 4;

  localparam logic [DW-1:0] D0 = 32'h1111_1111;
  localparam logic [DW-1:0] D1 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] D2 = 32'h2222_2222;
  localparam logic [DW-1:0] D3 = 32'h3333_3333;

  logic                       clk;
  logic                       rst;
  logic [NR-1:0]              req_valid;
  logic [NR-1:0]              req_we;
  logic [NR-1:0][AW-1:0]      req_addr;
  logic [NR-1:0][DW-1:0]      req_wdata;
  logic                       clear_req;

  logic [NR-1:0]  ready2, rsp2, ready1, rsp1;
  logic [DW-1:0]  rdata2, rdata1, din2, din1, dout2, dout2_q, dout1;
  logic           busy2, en2, we2, busy1, en1, we1;
  logic [AW-1:0]  addr2, addr1;

  logic [DW-1:0]  mem2 [SZ];
  logic [DW-1:0]  mem1 [SZ];

  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SIZE(SZ), .LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready2), .rsp_valid(rsp2), .rsp_rdata(rdata2),
    .clear_req(clear_req), .busy(busy2), .ram_en(en2), .ram_we(we2), .ram_addr(addr2),
    .ram_din(din2), .ram_dout(dout2)
  );

  ram_port_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SIZE(SZ), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready1), .rsp_valid(rsp1), .rsp_rdata(rdata1),
    .clear_req(clear_req), .busy(busy1), .ram_en(en1), .ram_we(we1), .ram_addr(addr1),
    .ram_din(din1), .ram_dout(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs: two-cycle and one-cycle read latency
  always @(posedge clk) begin
    if (en2 && we2) mem2[addr2] <= din2;
    dout2_q <= (en2 && !we2) ? mem2[addr2] : 32'h0;
    dout2   <= dout2_q;
  end

  always @(posedge clk) begin
    if (en1 && we1) mem1[addr1] <= din1;
    if (en1 && !we1) dout1 <= mem1[addr1];
  end

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] we;
    logic [NR-1:0] ready;
    logic [NR-1:0] rsp2;
    logic [NR-1:0] rsp1;
    logic [DW-1:0] data2;
    logic [DW-1:0] data1;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < int'(SZ); k++) begin
      @(negedge clk);
      chk($sformatf("%s busy k=%0d", tag, k), 32'(busy2), 32'd1);
      chk($sformatf("%s we k=%0d", tag, k), 32'(we2), 32'd1);
      chk($sformatf("%s addr k=%0d", tag, k), 32'(addr2), 32'(k));
      chk($sformatf("%s din k=%0d", tag, k), din2, 32'h0);
      chk($sformatf("%s ready k=%0d", tag, k), 32'(ready2), 32'h0);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            valid    we       ready    rsp2     rsp1     data2  data1
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[1]  = '{4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[2]  = '{4'b0110, 4'b0110, 4'b0010, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[3]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[4]  = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 32'h0, D1};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, D1,    32'h0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[8]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 32'h0, D0};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0001, 4'b0010, D0,    D1};
    tbl[10] = '{4'b1111, 4'b0000, 4'b1000, 4'b0010, 4'b0100, D1,    D2};
    tbl[11] = '{4'b1111, 4'b0000, 4'b0001, 4'b0100, 4'b1000, D2,    D1};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, D1,    D0};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, D0,    32'h0};
    tbl[14] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[15] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 32'h0, D2};
    tbl[16] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, D2,    D2};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, D2,    D2};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, D2,    32'h0};
    tbl[19] = '{4'b1001, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[20] = '{4'b1001, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 32'h0, D1};
    tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, D1,    D0};
    tbl[22] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, D0,    32'h0};

    req_addr[0] = 4'h2; req_wdata[0] = D0;
    req_addr[1] = 4'h5; req_wdata[1] = D1;
    req_addr[2] = 4'h9; req_wdata[2] = D2;
    req_addr[3] = 4'h5; req_wdata[3] = D3;

    // Reset state with requests and a clear pending
    rst = 1'b1; req_valid = 4'b1111; req_we = 4'b0000; clear_req = 1'b1;
    #3;
    chk("rst ready", 32'(ready2), 32'h0);
    chk("rst rsp_valid", 32'(rsp2), 32'h0);
    chk("rst ram_en", 32'(en2), 32'h0);
    chk("rst ram_we", 32'(we2), 32'h0);
    chk("rst busy", 32'(busy2), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; clear_req = 1'b0; req_valid = 4'b0001;

    // Power-up sweep; a clear_req pulse mid-sweep must not queue a second one
    for (int k = 0; k < int'(SZ); k++) begin
      clear_req = (k == 3);
      @(negedge clk);
      chk($sformatf("init busy k=%0d", k), 32'(busy2), 32'd1);
      chk($sformatf("init we k=%0d", k), 32'(we2), 32'd1);
      chk($sformatf("init addr k=%0d", k), 32'(addr2), 32'(k));
      chk($sformatf("init din k=%0d", k), din2, 32'h0);
      chk($sformatf("init ready k=%0d", k), 32'(ready2), 32'h0);
      step();
    end
    clear_req = 1'b0;

    for (int i = 0; i < 23; i++) begin
      req_valid = tbl[i].valid;
      req_we    = tbl[i].we;
      @(negedge clk);
      chk($sformatf("v%0d busy", i), 32'(busy2), 32'h0);
      chk($sformatf("v%0d ready L2", i), 32'(ready2), 32'(tbl[i].ready));
      chk($sformatf("v%0d ready L1", i), 32'(ready1), 32'(tbl[i].ready));
      chk($sformatf("v%0d ram_en", i), 32'(en2), 32'(|tbl[i].ready));
      chk($sformatf("v%0d rsp_valid L2", i), 32'(rsp2), 32'(tbl[i].rsp2));
      chk($sformatf("v%0d rsp_valid L1", i), 32'(rsp1), 32'(tbl[i].rsp1));
      if (tbl[i].rsp2 != 4'b0000) chk($sformatf("v%0d rdata L2", i), rdata2, tbl[i].data2);
      if (tbl[i].rsp1 != 4'b0000) chk($sformatf("v%0d rdata L1", i), rdata1, tbl[i].data1);
      step();
    end

    // Drain: read accepted, clear next cycle, response still delivered, then sweep
    req_valid = 4'b0010; req_we = 4'b0000;
    @(negedge clk);
    chk("drain read grant", 32'(ready2), 32'b0010);
    step();
    clear_req = 1'b1;
    @(negedge clk);
    chk("clear blocks grant", 32'(ready2), 32'h0);
    chk("clear cycle busy", 32'(busy2), 32'h0);
    step();
    clear_req = 1'b0;
    @(negedge clk);
    chk("drain busy", 32'(busy2), 32'd1);
    chk("drain ready", 32'(ready2), 32'h0);
    chk("drain rsp_valid", 32'(rsp2), 32'b0010);
    chk("drain rdata", rdata2, D1);
    step();
    @(negedge clk);
    chk("drain idle busy", 32'(busy2), 32'd1);
    chk("drain idle en", 32'(en2), 32'h0);
    chk("drain idle rsp", 32'(rsp2), 32'h0);
    step();
    sweep("clr");
    @(negedge clk);
    chk("post-clear busy", 32'(busy2), 32'h0);
    chk("post-clear grant", 32'(ready2), 32'b0010);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post-clear rsp early", 32'(rsp2), 32'h0);
    step();
    @(negedge clk);
    chk("post-clear rsp", 32'(rsp2), 32'b0010);
    chk("post-clear rdata", rdata2, 32'h0);
    step();

    // Async reset at clr_cnt=7 restarts the sweep from address 0
    clear_req = 1'b1;
    @(negedge clk);
    chk("clr2 blocks", 32'(ready2), 32'h0);
    step();
    clear_req = 1'b0;
    @(negedge clk);
    chk("clr2 drain busy", 32'(busy2), 32'd1);
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("clr2 addr k=%0d", k), 32'(addr2), 32'(k));
      if (k != 7) step();
    end
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy2), 32'h0);
    chk("async rst en", 32'(en2), 32'h0);
    chk("async rst we", 32'(we2), 32'h0);
    step();
    rst = 1'b0;
    sweep("restart");
    @(negedge clk);
    chk("restart done busy", 32'(busy2), 32'h0);
    step();

    // Reset while a read is in flight drops its response
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rstrd grant", 32'(ready2), 32'b0001);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstrd rsp in reset", 32'(rsp2), 32'h0);
    step();
    @(negedge clk);
    chk("rstrd rsp held", 32'(rsp2), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd rsp after", 32'(rsp2), 32'h0);
    chk("rstrd sweep addr", 32'(addr2), 32'h0);
    step();
    @(negedge clk);
    chk("rstrd rsp after2", 32'(rsp2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
